azimuth_frame_loader: RTL and testbench

- Upstream stage of the azimuth signal generator.
- Receives per-sweep target bitmaps from DMA over AXI-Stream and assembles them into a SIZE-bit back buffer.
- On each azimuth trigger, swaps the back buffer into the active DATA vector consumed by the generator.
- Emits a retimed trigger aligned with the DATA update, so the generator restarts its clock mask on fresh data.

---
 rtl/azimuth_frame_loader_if.sv | 33 +++
 rtl/azimuth_frame_loader.sv | 167 ++++++++++++++++
 tb/tb_azimuth_frame_loader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/azimuth_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : azimuth_frame_loader_if
// Description : AXI-Stream word channel that carries per-sweep target bitmap
//               words from the DMA engine into the azimuth frame loader.
//               Signals: tdata (frame word), tvalid (word valid),
//                        tready (sink can accept), tlast (last word of frame).
//               Modports: master (DMA side), slave (loader side).
// Revision    : 1.0 - initial release
// ============================================================================
interface azimuth_frame_loader_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/azimuth_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : azimuth_frame_loader
// Description : Assembles per-sweep target bitmaps arriving over AXI-Stream
//               into a SIZE-bit back buffer and, on each azimuth trigger,
//               swaps it into the active data vector used by the azimuth
//               signal generator. A retimed trigger is emitted in the same
//               cycle the data vector changes.
// Ports       : clk          - system clock, all logic on rising edge
//               rst          - synchronous active-high reset
//               en           - block enable; low flushes to idle
//               trig         - one-cycle azimuth sweep trigger
//               s_axis       - AXI-Stream slave (tdata/tvalid/tready/tlast)
//               data         - active frame bitmap to the generator
//               trig_out     - one-cycle trigger coincident with data update
//               frame_ready  - back buffer holds a complete frame
//               underrun     - pulse: trigger arrived without a full frame
//               frame_err    - pulse: tlast position mismatch
//               sweep_cnt    - number of successful swaps (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module azimuth_frame_loader #(
  parameter int SIZE       = 3200,
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  en,
  input  wire logic                  trig,
  azimuth_frame_loader_if.slave      s_axis,
  output logic [SIZE-1:0]            data,
  output logic                       trig_out,
  output logic                       frame_ready,
  output logic                       underrun,
  output logic                       frame_err,
  output logic [CNT_WIDTH-1:0]       sweep_cnt
);

  localparam int NWORDS = (SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_tready;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_WIDTH-1:0] r_back [NWORDS];
  logic [SIZE-1:0]       w_back_flat;
  logic                  w_beat;
  logic                  w_last_idx;

  assign s_axis.tready = r_tready;
  assign w_beat        = s_axis.tvalid && r_tready;
  assign w_last_idx    = (r_idx == IDX_W'(NWORDS - 1));

  // Flatten the word array into the frame vector; bits of the final word
  // that fall beyond SIZE are simply not forwarded.
  for (genvar w = 0; w < NWORDS; w++) begin : g_pack
    if ((w + 1) * WORD_WIDTH <= SIZE) begin : g_full
      assign w_back_flat[w*WORD_WIDTH +: WORD_WIDTH] = r_back[w];
    end else begin : g_part
      assign w_back_flat[SIZE-1:w*WORD_WIDTH] = r_back[w][SIZE-w*WORD_WIDTH-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = FILL;
        // A completing beat always lands in FULL, even if a trigger arrives
        // in the same cycle; that trigger is reported as an underrun.
        FILL:    if (w_beat && w_last_idx) w_state_next = FULL;
        FULL:    if (trig) w_state_next = FILL;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Handshake and status flags are registered decodes of the next state so
  // they change in the same cycle as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tready    <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      r_tready    <= (w_state_next == FILL);
      frame_ready <= (w_state_next == FULL);
    end
  end

  // --------------------------------------------------------------------------
  // Datapath: back buffer fill, swap, pulses and sweep counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= '0;
      data      <= '0;
      trig_out  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      sweep_cnt <= '0;
      for (int w = 0; w < NWORDS; w++) r_back[w] <= '0;
    end else begin
      trig_out  <= 1'b0;
      underrun  <= 1'b0;
      frame_err <= 1'b0;
      if (!en) begin
        // Flush: partial frame and active data are dropped, counter is kept.
        r_idx <= '0;
        data  <= '0;
        for (int w = 0; w < NWORDS; w++) r_back[w] <= '0;
      end else if (r_state == FILL) begin
        if (trig) begin
          data     <= '0;
          trig_out <= 1'b1;
          underrun <= 1'b1;
        end
        if (w_beat) begin
          if (w_last_idx) begin
            r_back[r_idx] <= s_axis.tdata;
            r_idx         <= '0;
            frame_err     <= !s_axis.tlast;
          end else if (s_axis.tlast) begin
            // Early end of frame: abandon the partial frame entirely.
            r_idx     <= '0;
            frame_err <= 1'b1;
            for (int w = 0; w < NWORDS; w++) r_back[w] <= '0;
          end else begin
            r_back[r_idx] <= s_axis.tdata;
            r_idx         <= r_idx + 1'b1;
          end
        end
      end else if ((r_state == FULL) && trig) begin
        data      <= w_back_flat;
        trig_out  <= 1'b1;
        sweep_cnt <= sweep_cnt + 1'b1;
        r_idx     <= '0;
        for (int w = 0; w < NWORDS; w++) r_back[w] <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_azimuth_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_azimuth_frame_loader
// Description : Directed self-checking bench for azimuth_frame_loader:
//               full frame swap, underrun, early tlast, back-pressure in
//               FULL, completing beat coincident with trigger, enable flush
//               and mid-frame reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_azimuth_frame_loader;

  localparam int SIZE = 3200;
  localparam int WW   = 32;
  localparam int CW   = 16;
  localparam int NW   = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            trig;
  logic [SIZE-1:0] data;
  logic            trig_out;
  logic            frame_ready;
  logic            underrun;
  logic            frame_err;
  logic [CW-1:0]   sweep_cnt;

  int checks   = 0;
  int failures = 0;

  azimuth_frame_loader_if #(.WORD_WIDTH(WW)) axis ();

  azimuth_frame_loader #(
    .SIZE(SIZE), .WORD_WIDTH(WW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig), .s_axis(axis),
    .data(data), .trig_out(trig_out), .frame_ready(frame_ready),
    .underrun(underrun), .frame_err(frame_err), .sweep_cnt(sweep_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] word_val(int seed, int k);
    return WW'((seed << 24) | (k + 1));
  endfunction

  function automatic logic [SIZE-1:0] exp_frame(int seed);
    logic [SIZE-1:0] f;
    f = '0;
    for (int k = 0; k < NW; k++) f[k*WW +: WW] = word_val(seed, k);
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; trig = 1'b0;
    axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic enable();
    en = 1'b1;
    step();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  // Streams words first..first+count-1; tlast on word last_k; optionally
  // raises trig together with the final word of this call.
  task automatic send_words(int seed, int first, int count, int last_k, bit trig_last);
    for (int k = first; k < first + count; k++) begin
      int n = 0;
      while (axis.tready !== 1'b1 && n < 50) begin
        step();
        n++;
      end
      if (axis.tready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL tready_timeout word=%0d actual=%b required=1", k, axis.tready);
      end
      axis.tvalid = 1'b1;
      axis.tdata  = word_val(seed, k);
      axis.tlast  = (k == last_k);
      trig        = trig_last && (k == first + count - 1);
      step();
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      trig        = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (data !== '0) begin failures++; $display("FAIL reset_data actual_lo=%h required=0", data[31:0]); end
    checks++;
    if ({trig_out, frame_ready, underrun, frame_err, axis.tready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags actual=%b required=00000",
               {trig_out, frame_ready, underrun, frame_err, axis.tready});
    end
    checks++;
    if (sweep_cnt !== '0) begin failures++; $display("FAIL reset_sweep actual=%0d required=0", sweep_cnt); end
  endtask

  task automatic test_full_frame();
    logic [SIZE-1:0] e;
    do_reset(); enable();
    checks++;
    if (axis.tready !== 1'b1) begin failures++; $display("FAIL fill_tready actual=%b required=1", axis.tready); end
    send_words(0, 0, NW, NW - 1, 1'b0);
    checks++;
    if (frame_ready !== 1'b1 || axis.tready !== 1'b0) begin
      failures++;
      $display("FAIL full_flags actual=%b%b required=10", frame_ready, axis.tready);
    end
    pulse_trig();
    e = exp_frame(0);
    checks++;
    if (data[31:0] !== 32'd1 || data[3199:3168] !== 32'd100) begin
      failures++;
      $display("FAIL swap_ends actual=%0d/%0d required=1/100", data[31:0], data[3199:3168]);
    end
    checks++;
    if (data !== e) begin failures++; $display("FAIL swap_data actual_hi=%h required_hi=%h", data[SIZE-1 -: 32], e[SIZE-1 -: 32]); end
    checks++;
    if ({trig_out, underrun, axis.tready, frame_ready} !== 4'b1010) begin
      failures++;
      $display("FAIL swap_flags actual=%b required=1010", {trig_out, underrun, axis.tready, frame_ready});
    end
    checks++;
    if (sweep_cnt !== 16'd1) begin failures++; $display("FAIL swap_sweep actual=%0d required=1", sweep_cnt); end
    step();
    checks++;
    if (trig_out !== 1'b0) begin failures++; $display("FAIL trig_out_width actual=%b required=0", trig_out); end
  endtask

  task automatic test_underrun();
    logic [SIZE-1:0] e;
    do_reset(); enable();
    send_words(1, 0, 40, -1, 1'b0);
    pulse_trig();
    checks++;
    if ({underrun, trig_out} !== 2'b11 || data !== '0) begin
      failures++;
      $display("FAIL underrun_pulse actual=%b%b data_lo=%h required=11 data=0", underrun, trig_out, data[31:0]);
    end
    checks++;
    if (sweep_cnt !== 16'd0) begin failures++; $display("FAIL underrun_sweep actual=%0d required=0", sweep_cnt); end
    send_words(1, 40, 60, NW - 1, 1'b0);
    checks++;
    if (frame_ready !== 1'b1 || frame_err !== 1'b0) begin
      failures++;
      $display("FAIL underrun_resume_ready actual=%b%b required=10", frame_ready, frame_err);
    end
    pulse_trig();
    e = exp_frame(1);
    checks++;
    if (data !== e || sweep_cnt !== 16'd1 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_swap actual_lo=%h sweep=%0d required_lo=%h sweep=1", data[31:0], sweep_cnt, e[31:0]);
    end
  endtask

  task automatic test_early_tlast();
    logic [SIZE-1:0] e;
    do_reset(); enable();
    send_words(2, 0, 11, 10, 1'b0);
    checks++;
    if (frame_err !== 1'b1 || frame_ready !== 1'b0 || axis.tready !== 1'b1) begin
      failures++;
      $display("FAIL early_tlast actual=%b%b%b required=101", frame_err, frame_ready, axis.tready);
    end
    step();
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL early_tlast_width actual=%b required=0", frame_err); end
    send_words(3, 0, NW, NW - 1, 1'b0);
    pulse_trig();
    e = exp_frame(3);
    checks++;
    if (data !== e || sweep_cnt !== 16'd1) begin
      failures++;
      $display("FAIL early_tlast_swap actual_lo=%h actual_hi=%h required_lo=%h required_hi=%h",
               data[31:0], data[SIZE-1 -: 32], e[31:0], e[SIZE-1 -: 32]);
    end
  endtask

  task automatic test_full_hold();
    logic [SIZE-1:0] e;
    int bad = 0;
    do_reset(); enable();
    send_words(4, 0, NW, NW - 1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      axis.tvalid = 1'b1;
      axis.tdata  = word_val(5, i);
      axis.tlast  = (i == 19);
      step();
      if (axis.tready !== 1'b0) bad++;
    end
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    checks++;
    if (bad != 0 || frame_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_tready actual_bad_cycles=%0d ready=%b required=0 ready=1", bad, frame_ready);
    end
    pulse_trig();
    e = exp_frame(4);
    checks++;
    if (data !== e) begin
      failures++;
      $display("FAIL hold_swap actual_lo=%h required_lo=%h", data[31:0], e[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [SIZE-1:0] e;
    do_reset(); enable();
    send_words(6, 0, NW - 1, NW - 1, 1'b0);
    send_words(6, NW - 1, 1, NW - 1, 1'b1);
    checks++;
    if ({underrun, trig_out, frame_ready} !== 3'b111 || data !== '0) begin
      failures++;
      $display("FAIL same_cycle actual=%b%b%b data_lo=%h required=111 data=0",
               underrun, trig_out, frame_ready, data[31:0]);
    end
    pulse_trig();
    e = exp_frame(6);
    checks++;
    if (data !== e || sweep_cnt !== 16'd1 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_swap actual_hi=%h sweep=%0d required_hi=%h sweep=1",
               data[SIZE-1 -: 32], sweep_cnt, e[SIZE-1 -: 32]);
    end
  endtask

  task automatic test_en_flush();
    logic [SIZE-1:0] e;
    do_reset(); enable();
    send_words(8, 0, NW, NW - 1, 1'b0);
    pulse_trig();
    send_words(7, 0, 50, -1, 1'b0);
    en = 1'b0; trig = 1'b1;
    step();
    trig = 1'b0;
    checks++;
    if ({axis.tready, trig_out, underrun, frame_err, frame_ready} !== 5'b0 || data !== '0) begin
      failures++;
      $display("FAIL flush actual=%b data_lo=%h required=00000 data=0",
               {axis.tready, trig_out, underrun, frame_err, frame_ready}, data[31:0]);
    end
    checks++;
    if (sweep_cnt !== 16'd1) begin failures++; $display("FAIL flush_sweep actual=%0d required=1", sweep_cnt); end
    step();
    enable();
    send_words(9, 0, NW, NW - 1, 1'b0);
    pulse_trig();
    e = exp_frame(9);
    checks++;
    if (data !== e || sweep_cnt !== 16'd2) begin
      failures++;
      $display("FAIL flush_resume actual_lo=%h sweep=%0d required_lo=%h sweep=2", data[31:0], sweep_cnt, e[31:0]);
    end
    send_words(10, 0, 30, -1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({axis.tready, trig_out, underrun, frame_err, frame_ready} !== 5'b0 || data !== '0 || sweep_cnt !== '0) begin
      failures++;
      $display("FAIL mid_reset actual=%b data_lo=%h sweep=%0d required=00000 data=0 sweep=0",
               {axis.tready, trig_out, underrun, frame_err, frame_ready}, data[31:0], sweep_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_underrun();
    test_early_tlast();
    test_full_hold();
    test_back_to_back();
    test_en_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
